// File: rtl/bank_peak_scheduler_if.sv
// Handshake bundle between the peak scheduler, the magnitude RAM and the LED mapper.
// The slave modport is the scheduler's view of the bundle.
interface bank_peak_scheduler_if #(
    parameter int MAG_W = 24
);
    logic              frame_start;
    logic              rd_en;
    logic [3:0]        rd_addr;
    logic [MAG_W-1:0]  rd_data;
    logic              busy;
    logic [4:0]        best_bank;
    logic [MAG_W-1:0]  best_mag;
    logic              update;

    modport slave (
        input  frame_start, rd_data,
        output rd_en, rd_addr, busy, best_bank, best_mag, update
    );

    modport master (
        output frame_start, rd_data,
        input  rd_en, rd_addr, busy, best_bank, best_mag, update
    );
endinterface

// File: rtl/bank_peak_scheduler.sv
// Per-frame scan of 16 bank magnitudes, picking the dominant bank with a silence gate and hysteresis.
// best_bank == 16 is the blank code that switches the LEDs off.
module bank_peak_scheduler #(
    parameter int               MAG_W          = 24,
    parameter logic [MAG_W-1:0] SILENCE_THRESH = 24'd4096,
    parameter logic [MAG_W-1:0] HYST           = 24'd1024
) (
    input  logic                   clk,
    input  logic                   reset,
    bank_peak_scheduler_if.slave   io_bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        DECIDE = 2'd3
    } state_t;

    localparam logic [4:0] BLANK = 5'd16;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_rd_en;
    logic              w_busy;

    logic [3:0]        r_rd_addr;
    logic              r_rd_en_d;
    logic [3:0]        r_addr_d;
    logic [MAG_W-1:0]  r_max;
    logic [3:0]        r_max_idx;
    logic [MAG_W-1:0]  r_cur_mag;
    logic [4:0]        r_best_bank;
    logic [MAG_W-1:0]  r_best_mag;
    logic              r_update;

    logic [MAG_W:0]    w_cur_plus_hyst;
    logic              w_challenger_wins;
    logic [4:0]        w_dec_bank;
    logic [MAG_W-1:0]  w_dec_mag;

    always_comb begin
        w_state_next = r_state;
        w_rd_en      = 1'b0;
        w_busy       = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (io_bus.frame_start) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                w_rd_en = 1'b1;
                if (r_rd_addr == 4'd15) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN:   w_state_next = DECIDE;
            DECIDE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // One extra bit so a current magnitude near full scale cannot wrap past the challenger.
    assign w_cur_plus_hyst   = {1'b0, r_cur_mag} + {1'b0, HYST};
    assign w_challenger_wins = ({1'b0, r_max} > w_cur_plus_hyst);

    always_comb begin
        w_dec_bank = r_best_bank;
        w_dec_mag  = r_cur_mag;
        if (r_max < SILENCE_THRESH) begin
            w_dec_bank = BLANK;
            w_dec_mag  = '0;
        end else if (r_best_bank == BLANK) begin
            w_dec_bank = {1'b0, r_max_idx};
            w_dec_mag  = r_max;
        end else if ({1'b0, r_max_idx} == r_best_bank) begin
            w_dec_bank = r_best_bank;
            w_dec_mag  = r_max;
        end else if (w_challenger_wins) begin
            w_dec_bank = {1'b0, r_max_idx};
            w_dec_mag  = r_max;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rd_addr   <= 4'd0;
            r_rd_en_d   <= 1'b0;
            r_addr_d    <= 4'd0;
            r_max       <= '0;
            r_max_idx   <= 4'd0;
            r_cur_mag   <= '0;
            r_best_bank <= BLANK;
            r_best_mag  <= '0;
            r_update    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_rd_en_d <= w_rd_en;
            r_addr_d  <= r_rd_addr;
            r_update  <= (r_state == DECIDE);

            if (r_state == READ) begin
                r_rd_addr <= (r_rd_addr == 4'd15) ? 4'd0 : r_rd_addr + 4'd1;
            end

            if (r_state == IDLE && io_bus.frame_start) begin
                r_cur_mag <= '0;
            end

            // Word returned for the address issued one cycle earlier; bank 0 seeds the max.
            if (r_rd_en_d) begin
                if (r_addr_d == 4'd0 || io_bus.rd_data > r_max) begin
                    r_max     <= io_bus.rd_data;
                    r_max_idx <= r_addr_d;
                end
                if (r_best_bank == {1'b0, r_addr_d}) begin
                    r_cur_mag <= io_bus.rd_data;
                end
            end

            if (r_state == DECIDE) begin
                r_best_bank <= w_dec_bank;
                r_best_mag  <= w_dec_mag;
            end
        end
    end

    assign io_bus.rd_en     = w_rd_en;
    assign io_bus.rd_addr   = r_rd_addr;
    assign io_bus.busy      = w_busy;
    assign io_bus.best_bank = r_best_bank;
    assign io_bus.best_mag  = r_best_mag;
    assign io_bus.update    = r_update;
endmodule

// File: tb/tb_bank_peak_scheduler.sv
// Scoreboard bench for bank_peak_scheduler: a behavioural RAM, a reference decision model
// and a monitor that pops the expected result on every update strobe.
module tb_bank_peak_scheduler;
    localparam int MAG_W = 24;

    logic clk;
    logic reset;
    bank_peak_scheduler_if #(.MAG_W(MAG_W)) bus_if();

    bank_peak_scheduler #(
        .MAG_W(MAG_W),
        .SILENCE_THRESH(24'd4096),
        .HYST(24'd1024)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [MAG_W-1:0] mem [16];
    always @(posedge clk) begin
        if (bus_if.rd_en) bus_if.rd_data <= mem[bus_if.rd_addr];
    end

    int n_err = 0;
    int n_chk = 0;
    logic [28:0] exp_q[$];
    logic [4:0]  exp_bank = 5'd16;
    logic [23:0] exp_mag  = 24'd0;
    int frame_no = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, req);
        end
    endtask

    // Reference decision computed from the RAM image and the model's current selection.
    task automatic model(output logic [4:0] nb, output logic [23:0] nm);
        longint mx;
        longint cur;
        int win;
        mx  = mem[0];
        win = 0;
        for (int i = 1; i < 16; i++) begin
            if (longint'(mem[i]) > mx) begin
                mx  = mem[i];
                win = i;
            end
        end
        cur = (exp_bank == 5'd16) ? 0 : longint'(mem[exp_bank[3:0]]);
        if (mx < 4096) begin
            nb = 5'd16; nm = 24'd0;
        end else if (exp_bank == 5'd16 || win == int'(exp_bank) || mx > cur + 1024) begin
            nb = 5'(win); nm = 24'(mx);
        end else begin
            nb = exp_bank; nm = 24'(cur);
        end
    endtask

    always @(negedge clk) begin
        if (bus_if.update) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_update", 32'd1, 32'd0);
            end else begin
                logic [28:0] e;
                e = exp_q.pop_front();
                check("sb_bank", 32'(bus_if.best_bank), 32'(e[28:24]));
                check("sb_mag", 32'(bus_if.best_mag), 32'(e[23:0]));
                $display("frame %0d: best_bank=%0d best_mag=%0d (exp %0d/%0d)",
                         frame_no, bus_if.best_bank, bus_if.best_mag, e[28:24], e[23:0]);
            end
        end
    end

    task automatic fill(input logic [23:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic run_frame(input bit extra_starts, input bit reset_mid);
        logic [4:0]  eb;
        logic [23:0] em;
        bit aborted;
        aborted = 1'b0;
        frame_no++;
        if (!reset_mid) begin
            model(eb, em);
            exp_q.push_back({eb, em});
            exp_bank = eb;
            exp_mag  = em;
        end
        @(negedge clk);
        bus_if.frame_start = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= 20 && !aborted; j++) begin
            @(negedge clk);
            bus_if.frame_start = extra_starts && (j == 4 || j == 17);
            if (reset_mid && j == 9) begin
                reset = 1'b1;
                #1;
                check("rst_mid_bank", 32'(bus_if.best_bank), 32'd16);
                check("rst_mid_mag", 32'(bus_if.best_mag), 32'd0);
                check("rst_mid_update", 32'(bus_if.update), 32'd0);
                check("rst_mid_rd_en", 32'(bus_if.rd_en), 32'd0);
                check("rst_mid_busy", 32'(bus_if.busy), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                exp_bank = 5'd16;
                exp_mag  = 24'd0;
                aborted  = 1'b1;
            end else begin
                check($sformatf("rd_en_c%0d", j), 32'(bus_if.rd_en), 32'(j <= 16));
                if (j <= 16) check($sformatf("rd_addr_c%0d", j), 32'(bus_if.rd_addr), 32'(j - 1));
                check($sformatf("busy_c%0d", j), 32'(bus_if.busy), 32'(j <= 18));
                check($sformatf("update_c%0d", j), 32'(bus_if.update), 32'(j == 19));
            end
        end
        bus_if.frame_start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        bus_if.frame_start = 1'b0;
        fill(24'd0);
        #2 reset = 1'b1;
        #1;
        check("rst_bank", 32'(bus_if.best_bank), 32'd16);
        check("rst_mag", 32'(bus_if.best_mag), 32'd0);
        check("rst_update", 32'(bus_if.update), 32'd0);
        check("rst_rd_en", 32'(bus_if.rd_en), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_addr", 32'(bus_if.rd_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_rd_en", 32'(bus_if.rd_en), 32'd0);
        end

        // single peak
        fill(24'd100); mem[5] = 24'd50000;
        run_frame(1'b0, 1'b0);
        // silence, then all at threshold -> bank 0 from blank
        fill(24'd4095);
        run_frame(1'b0, 1'b0);
        fill(24'd4096);
        run_frame(1'b0, 1'b0);
        // back to blank, then tie -> lowest index
        fill(24'd10);
        run_frame(1'b0, 1'b0);
        fill(24'd0); mem[3] = 24'd30000; mem[9] = 24'd30000;
        run_frame(1'b0, 1'b0);
        // move to bank 5, then hysteresis hold / switch
        fill(24'd50); mem[5] = 24'd30000;
        run_frame(1'b0, 1'b0);
        fill(24'd50); mem[5] = 24'd20000; mem[7] = 24'd20900;
        run_frame(1'b0, 1'b0);
        mem[7] = 24'd21024;
        run_frame(1'b0, 1'b0);
        mem[7] = 24'd21025;
        run_frame(1'b0, 1'b0);
        // near full scale: cur+HYST must not wrap
        fill(24'd50); mem[7] = 24'hFFFF00;
        run_frame(1'b0, 1'b0);
        mem[2] = 24'hFFFFFF;
        run_frame(1'b0, 1'b0);
        // frame_start while busy is ignored
        fill(24'd200); mem[11] = 24'd90000;
        run_frame(1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("no_extra_scan", 32'(bus_if.busy), 32'd0);
        end
        // reset mid-scan, then a fresh scan from blank
        fill(24'd300); mem[14] = 24'd70000;
        run_frame(1'b0, 1'b1);
        run_frame(1'b0, 1'b0);
        // a few random frames
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) mem[i] = 24'($urandom_range(0, 40000));
            run_frame(1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("sb_left", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
